// File: rtl/perf_sampler.sv
// Periodic sampler for an upstream read-and-clear event counter: saturating total, peak and a one-entry sample buffer.
// Build option: define PERF_SAMPLER_MAX_EN to implement the max_o peak tracker (otherwise max_o is tied to 0).
module perf_sampler #(
   parameter int CNT_W  = 4,
   parameter int ACC_W  = 16,
   parameter int PERIOD = 8,
   parameter int DROP_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable_i,
   input  logic              clear_i,
   output logic              sw_req_o,
   input  logic [CNT_W-1:0]  p_count_i,
   output logic              sample_valid_o,
   input  logic              sample_ready_i,
   output logic [CNT_W-1:0]  sample_data_o,
   output logic [ACC_W-1:0]  total_o,
   output logic [CNT_W-1:0]  max_o,
   output logic [DROP_W-1:0] drop_cnt_o,
   output logic              busy_o,
   output logic [1:0]        dbg_state_o
);

   localparam int TMR_W = $clog2(PERIOD);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PERIOD - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic                valid_q, valid_d;
   logic [CNT_W-1:0]    data_q, data_d;
   logic [ACC_W-1:0]    total_q, total_d, total_base;
   logic [ACC_W:0]      sum;
   logic [DROP_W-1:0]   drop_q, drop_d, drop_base;
   logic                sw_req, drop_evt;

   // The enabling cycle is already timer slot 0, so RUN is entered at slot 1.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      sw_req  = 1'b0;
      case (state_q)
         S_IDLE: begin
            timer_d = '0;
            if (enable_i) begin
               state_d = S_RUN;
               timer_d = TMR_W'(1);
            end
         end
         S_RUN: begin
            sw_req  = (timer_q == TMR_LAST);
            timer_d = (timer_q == TMR_LAST) ? '0 : timer_q + TMR_W'(1);
            if (!enable_i) begin
               state_d = (timer_q == TMR_LAST) ? S_IDLE : S_FLUSH;
               timer_d = '0;
            end
         end
         S_FLUSH: begin
            sw_req  = 1'b1;
            state_d = S_IDLE;
            timer_d = '0;
         end
         default: begin
            state_d = S_IDLE;
            timer_d = '0;
         end
      endcase
   end

   // Sample handshake: the buffer transfers on any edge where valid and ready are both high;
   // a capture on that same edge reloads it, and a capture while valid && !ready overwrites and counts a drop.
   always_comb begin
      valid_d    = valid_q;
      data_d     = data_q;
      drop_evt   = sw_req && valid_q && !sample_ready_i;
      total_base = clear_i ? '0 : total_q;
      drop_base  = clear_i ? '0 : drop_q;
      sum        = {1'b0, total_base} + {{(ACC_W + 1 - CNT_W){1'b0}}, p_count_i};
      total_d    = total_base;
      drop_d     = drop_base;
      if (sw_req) begin
         valid_d = 1'b1;
         data_d  = p_count_i;
         total_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
      end else if (valid_q && sample_ready_i) begin
         valid_d = 1'b0;
      end
      if (drop_evt && (drop_base != '1)) begin
         drop_d = drop_base + DROP_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         total_q <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         total_q <= total_d;
         drop_q  <= drop_d;
      end
   end

`ifdef PERF_SAMPLER_MAX_EN
   logic [CNT_W-1:0] max_q, max_d, max_base;

   always_comb begin
      max_base = clear_i ? '0 : max_q;
      max_d    = max_base;
      if (sw_req && (p_count_i > max_base)) begin
         max_d = p_count_i;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         max_q <= '0;
      end else begin
         max_q <= max_d;
      end
   end

   assign max_o = max_q;
`else
   assign max_o = '0;
`endif

   assign sw_req_o       = sw_req;
   assign sample_valid_o = valid_q;
   assign sample_data_o  = data_q;
   assign total_o        = total_q;
   assign drop_cnt_o     = drop_q;
   assign busy_o         = (state_q != S_IDLE);
   assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_perf_sampler.sv
// Bench for perf_sampler: phase table, saturation and reset sequences, then random traffic against a window-level model.
module tb_perf_sampler;

   localparam int CNT_W  = 4;
   localparam int ACC_W  = 16;
   localparam int PERIOD = 8;
   localparam int DROP_W = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   // main instance
   logic en, trig, rdy, clr;
   logic sw_req, s_valid, busy;
   logic [CNT_W-1:0] p_count, s_data, mx;
   logic [ACC_W-1:0] total;
   logic [DROP_W-1:0] drop;
   logic [1:0] dbg;

   // narrow-accumulator instance for saturation
   logic en2, trig2;
   logic sw_req2, s_valid2, busy2;
   logic [CNT_W-1:0] p_count2, s_data2, mx2;
   logic [3:0] total2;
   logic [DROP_W-1:0] drop2;
   logic [1:0] dbg2;

   perf_sampler #(.CNT_W(CNT_W), .ACC_W(ACC_W), .PERIOD(PERIOD), .DROP_W(DROP_W)) dut (
      .clk(clk), .reset_n(reset_n), .enable_i(en), .clear_i(clr), .sw_req_o(sw_req),
      .p_count_i(p_count), .sample_valid_o(s_valid), .sample_ready_i(rdy),
      .sample_data_o(s_data), .total_o(total), .max_o(mx), .drop_cnt_o(drop),
      .busy_o(busy), .dbg_state_o(dbg)
   );

   perf_sampler #(.CNT_W(CNT_W), .ACC_W(4), .PERIOD(9), .DROP_W(DROP_W)) dut_sat (
      .clk(clk), .reset_n(reset_n), .enable_i(en2), .clear_i(1'b0), .sw_req_o(sw_req2),
      .p_count_i(p_count2), .sample_valid_o(s_valid2), .sample_ready_i(1'b1),
      .sample_data_o(s_data2), .total_o(total2), .max_o(mx2), .drop_cnt_o(drop2),
      .busy_o(busy2), .dbg_state_o(dbg2)
   );

   // upstream event counters: read-and-clear, request-cycle event lands in the next window
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         p_count  <= '0;
         p_count2 <= '0;
      end else begin
         if (sw_req) p_count <= CNT_W'(trig);
         else if (p_count != CNT_W'(CNT_MAX)) p_count <= p_count + CNT_W'(trig);
         if (sw_req2) p_count2 <= CNT_W'(trig2);
         else if (p_count2 != CNT_W'(CNT_MAX)) p_count2 <= p_count2 + CNT_W'(trig2);
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int exp_max(input int v);
`ifdef PERF_SAMPLER_MAX_EN
      return v;
`else
      return 0;
`endif
   endfunction

   // window-level reference model
   bit m_run, m_flush, m_valid;
   int m_pos, m_cnt, m_data, m_total, m_max, m_drop;

   task automatic model_reset();
      m_run = 0; m_flush = 0; m_valid = 0;
      m_pos = 0; m_cnt = 0; m_data = 0; m_total = 0; m_max = 0; m_drop = 0;
   endtask

   function automatic bit model_req();
      return (m_run && (m_pos % PERIOD == PERIOD - 1)) || m_flush;
   endfunction

   task automatic model_edge();
      bit req, drop_evt;
      int s;
      req      = model_req();
      s        = m_cnt;
      drop_evt = req && m_valid && !rdy;
      m_cnt    = req ? int'(trig) : ((m_cnt + int'(trig) > CNT_MAX) ? CNT_MAX : m_cnt + int'(trig));
      if (clr) begin
         m_total = 0; m_max = 0; m_drop = 0;
      end
      if (req) begin
         m_total = (m_total + s > (1 << ACC_W) - 1) ? (1 << ACC_W) - 1 : m_total + s;
         if (s > m_max) m_max = s;
         m_data  = s;
         m_valid = 1;
      end else if (m_valid && rdy) begin
         m_valid = 0;
      end
      if (drop_evt) m_drop = (m_drop == (1 << DROP_W) - 1) ? m_drop : m_drop + 1;
      if (m_flush) begin
         m_flush = 0;
      end else if (m_run) begin
         if (!en) begin
            m_run = 0;
            if (m_pos % PERIOD != PERIOD - 1) m_flush = 1;
         end else begin
            m_pos++;
         end
      end else if (en) begin
         m_run = 1;
         m_pos = 1;
      end
   endtask

   // one clock: check request/busy before the edge, update model, check registered outputs after it
   task automatic step();
      chk("req", 32'(sw_req), 32'(model_req()));
      chk("busy", 32'(busy), 32'(m_run || m_flush));
      @(posedge clk);
      #1;
      model_edge();
      chk("valid", 32'(s_valid), 32'(m_valid));
      chk("data", 32'(s_data), 32'(m_data));
      chk("total", 32'(total), 32'(m_total));
      chk("max", 32'(mx), 32'(exp_max(m_max)));
      chk("drop", 32'(drop), 32'(m_drop));
   endtask

   typedef struct {
      logic en, trig, rdy, clr;
      int   n;
      logic req, busy, valid;
      int   data, total, mx, drop;
   } vec_t;

   function automatic vec_t mk(input logic e, t, r, c, input int n, input logic rq, b, v,
                               input int d, tot, m, dr);
      vec_t x;
      x.en = e; x.trig = t; x.rdy = r; x.clr = c; x.n = n;
      x.req = rq; x.busy = b; x.valid = v; x.data = d; x.total = tot; x.mx = m; x.drop = dr;
      return x;
   endfunction

   vec_t vecs[13];

   initial begin
      int first_req;
      int ready_bias;

      vecs[0]  = mk(1, 1, 1, 0, 7, 1, 1, 0, 0, 0, 0, 0);
      vecs[1]  = mk(1, 1, 1, 0, 1, 0, 1, 1, 7, 7, 7, 0);
      vecs[2]  = mk(1, 1, 1, 0, 8, 0, 1, 1, 8, 15, 8, 0);
      vecs[3]  = mk(1, 1, 1, 0, 8, 0, 1, 1, 8, 23, 8, 0);
      vecs[4]  = mk(1, 1, 0, 0, 8, 0, 1, 1, 8, 31, 8, 1);
      vecs[5]  = mk(1, 1, 0, 0, 8, 0, 1, 1, 8, 39, 8, 2);
      vecs[6]  = mk(1, 1, 1, 0, 1, 0, 1, 0, 8, 39, 8, 2);
      vecs[7]  = mk(1, 1, 1, 0, 6, 1, 1, 0, 8, 39, 8, 2);
      vecs[8]  = mk(1, 1, 1, 1, 1, 0, 1, 1, 8, 8, 8, 0);
      vecs[9]  = mk(1, 1, 1, 0, 3, 0, 1, 0, 8, 8, 8, 0);
      vecs[10] = mk(0, 0, 1, 0, 1, 1, 1, 0, 8, 8, 8, 0);
      vecs[11] = mk(0, 0, 1, 0, 1, 0, 0, 1, 4, 12, 8, 0);
      vecs[12] = mk(0, 0, 1, 0, 3, 0, 0, 0, 4, 12, 8, 0);

      // reset
      reset_n = 1'b0;
      en = 0; trig = 0; rdy = 1; clr = 0; en2 = 0; trig2 = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req", 32'(sw_req), 0);
      chk("rst_valid", 32'(s_valid), 0);
      chk("rst_total", 32'(total), 0);
      chk("rst_busy", 32'(busy), 0);
      reset_n = 1'b1;

      // saturation on the 4-bit accumulator: samples 8, 9, 9
      en2 = 1; trig2 = 1;
      repeat (9) step();
      chk("sat_total_1", 32'(total2), 8);
      repeat (9) step();
      chk("sat_total_2", 32'(total2), 15);
      repeat (9) step();
      chk("sat_total_3", 32'(total2), 15);
      chk("sat_data", 32'(s_data2), 9);
      chk("sat_max", 32'(mx2), 32'(exp_max(9)));
      en2 = 0; trig2 = 0;
      repeat (3) step();
      chk("sat_idle", 32'(busy2), 0);
      chk("sat_total_hold", 32'(total2), 15);

      // phase table: window, backpressure, clear collision, flush
      for (int i = 0; i < 13; i++) begin
         en = vecs[i].en; trig = vecs[i].trig; rdy = vecs[i].rdy; clr = vecs[i].clr;
         repeat (vecs[i].n) step();
         chk($sformatf("v%0d_req", i), 32'(sw_req), 32'(vecs[i].req));
         chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
         chk($sformatf("v%0d_valid", i), 32'(s_valid), 32'(vecs[i].valid));
         chk($sformatf("v%0d_data", i), 32'(s_data), 32'(vecs[i].data));
         chk($sformatf("v%0d_total", i), 32'(total), 32'(vecs[i].total));
         chk($sformatf("v%0d_max", i), 32'(mx), 32'(exp_max(vecs[i].mx)));
         chk($sformatf("v%0d_drop", i), 32'(drop), 32'(vecs[i].drop));
      end

      // reset mid-window at timer 4
      en = 1; trig = 1; rdy = 1; clr = 0;
      repeat (4) step();
      reset_n = 1'b0;
      #2;
      model_reset();
      chk("mid_rst_req", 32'(sw_req), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_valid", 32'(s_valid), 0);
      chk("mid_rst_data", 32'(s_data), 0);
      chk("mid_rst_total", 32'(total), 0);
      chk("mid_rst_max", 32'(mx), 0);
      chk("mid_rst_drop", 32'(drop), 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      first_req = -1;
      for (int c = 0; c < 20; c++) begin
         if (sw_req) begin
            first_req = c;
            break;
         end
         step();
      end
      chk("mid_rst_first_req", 32'(first_req), PERIOD - 1);

      // random traffic
      ready_bias = 3;
      for (int c = 0; c < 800; c++) begin
         if (c % 64 == 0) ready_bias = $urandom_range(0, 4);
         if ($urandom_range(0, 19) == 0) en = ~en;
         trig = 1'($urandom_range(0, 1));
         rdy  = ($urandom_range(0, 3) < ready_bias);
         clr  = ($urandom_range(0, 59) == 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
